// File: rtl/bus_pkg.sv
// Shared definitions for the two-device bus arbiter.
//   state_t          : arbiter FSM states (IDLE, OWN_1, OWN_2)
//   owner_t          : encoding of the last device that was granted the bus
//   MAX_HOLD_DEFAULT : default cap on consecutive cycles under contention
//   DATA_W_DEFAULT   : default bus / data port width
//   hold_cnt_width() : width needed to hold a count of 0..max_hold
package bus_pkg;

  localparam int MAX_HOLD_DEFAULT = 4;
  localparam int DATA_W_DEFAULT   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_1 = 2'd1,
    OWN_2 = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_1 = 1'b0,
    OWNER_2 = 1'b1
  } owner_t;

  function automatic int hold_cnt_width(input int max_hold);
    return $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/bus_hold_timer.sv
// Ownership hold counter for the bus arbiter.
// Counts how many consecutive cycles the current owner has held the bus.
//   clk, rst : clock and synchronous active-high reset (count -> 0)
//   start    : ownership begins next cycle; count loads 1
//   keep     : ownership continues next cycle; count increments, saturating
//   count    : current hold count, 0 when nobody owns the bus
//   expired  : count has reached MAX_HOLD
module bus_hold_timer
  import bus_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT,
  localparam int CW = hold_cnt_width(MAX_HOLD)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          keep,
  output logic [CW-1:0] count,
  output logic          expired
);

  assign expired = (count == CW'(MAX_HOLD));

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (start) begin
      count <= CW'(1);
    end else if (keep) begin
      // Saturate so an uncontested owner can sit on the bus forever
      // without the count wrapping back below MAX_HOLD.
      if (!expired) begin
        count <= count + CW'(1);
      end
    end else begin
      count <= '0;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-device round-robin bus arbiter with bounded hold time.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | nobody owns the bus, bus driven to zero
//   OWN_1 | device 1 owns the bus, bus = data_in_1, gnt_1 high
//   OWN_2 | device 2 owns the bus, bus = data_in_2, gnt_2 high
//
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   req_1, req_2           : bus requests, held while the bus is wanted
//   data_in_1, data_in_2   : data driven by each device
//   gnt_1, gnt_2           : registered grants (mutually exclusive)
//   bus                    : shared bus, combinational mux on state
//   bus_valid              : a grant is active
//   data_out_1, data_out_2 : bus readback to each device
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int N        = DATA_W_DEFAULT,
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_1,
  input  logic         req_2,
  input  logic [N-1:0] data_in_1,
  input  logic [N-1:0] data_in_2,
  output logic         gnt_1,
  output logic         gnt_2,
  output logic [N-1:0] bus,
  output logic         bus_valid,
  output logic [N-1:0] data_out_1,
  output logic [N-1:0] data_out_2
);

  localparam int CW = hold_cnt_width(MAX_HOLD);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("bus_arbiter: MAX_HOLD must be in 1..255");
  end

  state_t        state;
  state_t        state_nxt;
  owner_t        last_owner;
  logic [CW-1:0] hold_cnt;
  logic          hold_expired;
  logic          timer_start;
  logic          timer_keep;

  // Next-state decision. In an OWN state the owner gives up the bus
  // either by dropping its request or by being preempted once it has
  // held the bus MAX_HOLD cycles while the other device is waiting.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_1 && req_2) begin
          state_nxt = (last_owner == OWNER_2) ? OWN_1 : OWN_2;
        end else if (req_1) begin
          state_nxt = OWN_1;
        end else if (req_2) begin
          state_nxt = OWN_2;
        end else begin
          state_nxt = IDLE;
        end
      end
      OWN_1: begin
        if (!req_1) begin
          state_nxt = req_2 ? OWN_2 : IDLE;
        end else if (req_2 && hold_expired) begin
          state_nxt = OWN_2;
        end else begin
          state_nxt = OWN_1;
        end
      end
      OWN_2: begin
        if (!req_2) begin
          state_nxt = req_1 ? OWN_1 : IDLE;
        end else if (req_1 && hold_expired) begin
          state_nxt = OWN_1;
        end else begin
          state_nxt = OWN_2;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A handover between owners counts as a fresh entry, so the timer
  // reloads rather than continuing from the previous owner's count.
  assign timer_start = (state_nxt != IDLE) && (state_nxt != state);
  assign timer_keep  = (state_nxt != IDLE) && (state_nxt == state);

  bus_hold_timer #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (timer_start),
    .keep    (timer_keep),
    .count   (hold_cnt),
    .expired (hold_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gnt_1      <= 1'b0;
      gnt_2      <= 1'b0;
      // Device 1 wins the first tie after reset.
      last_owner <= OWNER_2;
    end else begin
      state <= state_nxt;
      gnt_1 <= (state_nxt == OWN_1);
      gnt_2 <= (state_nxt == OWN_2);
      if (timer_start) begin
        last_owner <= (state_nxt == OWN_1) ? OWNER_1 : OWNER_2;
      end
    end
  end

  always_comb begin
    bus = '0;
    case (state)
      OWN_1:   bus = data_in_1;
      OWN_2:   bus = data_in_2;
      default: bus = '0;
    endcase
  end

  assign bus_valid  = gnt_1 | gnt_2;
  assign data_out_1 = bus;
  assign data_out_2 = bus;

  a_grant_onehot : assert property (@(posedge clk) disable iff (rst)
    !(gnt_1 && gnt_2));

  a_hold_bounded : assert property (@(posedge clk) disable iff (rst)
    hold_cnt <= CW'(MAX_HOLD));

  a_grant_matches_state : assert property (@(posedge clk) disable iff (rst)
    (gnt_1 == (state == OWN_1)) && (gnt_2 == (state == OWN_2)));

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_1 = 1'b0;
  logic       req_2 = 1'b0;
  logic [7:0] d1 = 8'h00;
  logic [7:0] d2 = 8'h00;

  logic       g1_a, g2_a, bv_a;
  logic [7:0] bus_a, o1_a, o2_a;
  logic       g1_b, g2_b, bv_b;
  logic [7:0] bus_b, o1_b, o2_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.N(8), .MAX_HOLD(4)) dut4 (
    .clk(clk), .rst(rst), .req_1(req_1), .req_2(req_2),
    .data_in_1(d1), .data_in_2(d2),
    .gnt_1(g1_a), .gnt_2(g2_a), .bus(bus_a), .bus_valid(bv_a),
    .data_out_1(o1_a), .data_out_2(o2_a)
  );

  bus_arbiter #(.N(8), .MAX_HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .req_1(req_1), .req_2(req_2),
    .data_in_1(d1), .data_in_2(d2),
    .gnt_1(g1_b), .gnt_2(g2_b), .bus(bus_b), .bus_valid(bv_b),
    .data_out_1(o1_b), .data_out_2(o2_b)
  );

  // Reference model: who owns the bus, for how many consecutive cycles,
  // and who owned it last (1 or 2). owner 0 means nobody.
  typedef struct {
    int owner;
    int held;
    int last;
  } model_t;

  model_t m4, m1;

  function automatic model_t step(model_t m, bit r, bit r1, bit r2, int maxh);
    model_t n;
    int take;
    bit mine, other;
    n = m;
    if (r) begin
      n.owner = 0; n.held = 0; n.last = 2;
      return n;
    end
    if (m.owner == 0) begin
      if (r1 && r2)  take = (m.last == 1) ? 2 : 1;
      else if (r1)   take = 1;
      else if (r2)   take = 2;
      else           take = 0;
    end else begin
      mine  = (m.owner == 1) ? r1 : r2;
      other = (m.owner == 1) ? r2 : r1;
      if (!mine)                       take = other ? 3 - m.owner : 0;
      else if (other && m.held >= maxh) take = 3 - m.owner;
      else                             take = m.owner;
    end
    if (take == 0) begin
      n.held = 0;
    end else if (take != m.owner) begin
      n.held = 1;
      n.last = take;
    end else begin
      n.held = m.held + 1;
    end
    n.owner = take;
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input model_t m, input int maxh,
                     input logic g1, input logic g2, input logic bv,
                     input logic [7:0] b, input logic [7:0] o1, input logic [7:0] o2,
                     input logic [31:0] hc);
    logic [7:0] eb;
    eb = (m.owner == 1) ? d1 : (m.owner == 2) ? d2 : 8'h00;
    check({tag, "_gnt_1"}, 32'(g1), 32'(m.owner == 1));
    check({tag, "_gnt_2"}, 32'(g2), 32'(m.owner == 2));
    check({tag, "_both_gnt"}, 32'(g1 & g2), 32'd0);
    check({tag, "_bus_valid"}, 32'(bv), 32'(m.owner != 0));
    check({tag, "_bus"}, 32'(b), 32'(eb));
    check({tag, "_data_out_1"}, 32'(o1), 32'(eb));
    check({tag, "_data_out_2"}, 32'(o2), 32'(eb));
    if (m.owner != 0)
      check({tag, "_hold_cnt"}, hc, 32'((m.held < maxh) ? m.held : maxh));
  endtask

  // One clock: models sample the same inputs the DUTs sample, outputs
  // are compared 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    m4 = step(m4, rst, req_1, req_2, 4);
    m1 = step(m1, rst, req_1, req_2, 1);
    #1;
    cmp("mh4", m4, 4, g1_a, g2_a, bv_a, bus_a, o1_a, o2_a, 32'(dut4.hold_cnt));
    cmp("mh1", m1, 1, g1_b, g2_b, bv_b, bus_b, o1_b, o2_b, 32'(dut1.hold_cnt));
  endtask

  task automatic do_reset();
    rst = 1'b1; req_1 = 1'b0; req_2 = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    bit         r;
    bit         r1;
    bit         r2;
    logic [7:0] a;
    logic [7:0] b;
    bit         g1;
    bit         g2;
    logic [7:0] eb;
  } vec_t;

  function automatic vec_t mk(bit r, bit r1, bit r2, bit g1, bit g2, logic [7:0] eb);
    vec_t v;
    v.r = r; v.r1 = r1; v.r2 = r2; v.a = 8'hA5; v.b = 8'h3C;
    v.g1 = g1; v.g2 = g2; v.eb = eb;
    return v;
  endfunction

  vec_t vecs[14];

  initial begin
    int n;
    //             rst r1 r2  g1 g2 bus
    vecs[0]  = mk(1, 0, 0,   0, 0, 8'h00);
    vecs[1]  = mk(0, 1, 0,   1, 0, 8'hA5);
    vecs[2]  = mk(0, 0, 0,   0, 0, 8'h00);
    vecs[3]  = mk(1, 0, 0,   0, 0, 8'h00);
    vecs[4]  = mk(0, 1, 1,   1, 0, 8'hA5);
    vecs[5]  = mk(0, 0, 1,   0, 1, 8'h3C);
    vecs[6]  = mk(0, 0, 0,   0, 0, 8'h00);
    vecs[7]  = mk(0, 1, 1,   1, 0, 8'hA5);
    vecs[8]  = mk(0, 1, 1,   1, 0, 8'hA5);
    vecs[9]  = mk(0, 1, 1,   1, 0, 8'hA5);
    vecs[10] = mk(0, 1, 1,   1, 0, 8'hA5);
    vecs[11] = mk(0, 1, 1,   0, 1, 8'h3C);
    vecs[12] = mk(0, 1, 0,   1, 0, 8'hA5);
    vecs[13] = mk(1, 1, 1,   0, 0, 8'h00);

    m4 = '{owner: 0, held: 0, last: 2};
    m1 = '{owner: 0, held: 0, last: 2};

    for (int i = 0; i < 14; i++) begin
      rst = vecs[i].r; req_1 = vecs[i].r1; req_2 = vecs[i].r2;
      d1 = vecs[i].a; d2 = vecs[i].b;
      tick();
      check($sformatf("vec%0d_gnt_1", i), 32'(g1_a), 32'(vecs[i].g1));
      check($sformatf("vec%0d_gnt_2", i), 32'(g2_a), 32'(vecs[i].g2));
      check($sformatf("vec%0d_bus", i), 32'(bus_a), 32'(vecs[i].eb));
      check($sformatf("vec%0d_valid", i), 32'(bv_a), 32'(vecs[i].g1 | vecs[i].g2));
    end

    // Device 1 holds exactly 4 cycles once device 2 starts waiting.
    do_reset();
    d1 = 8'h11; d2 = 8'h22;
    req_1 = 1'b1;
    tick();
    n = g1_a ? 1 : 0;
    req_2 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (g1_a) n++;
      else break;
    end
    check("preempt_hold_len", 32'(n), 32'd4);
    check("preempt_next_gnt_2", 32'(g2_a), 32'd1);

    // Uncontested owner keeps the bus indefinitely.
    do_reset();
    req_2 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("alone_gnt_2", 32'(g2_a), 32'd1);
    end
    check("alone_hold_sat", 32'(dut4.hold_cnt), 32'd4);

    // Late arrival against a saturated counter preempts on first sight.
    req_1 = 1'b1;
    tick();
    check("late_preempt_gnt_1", 32'(g1_a), 32'd1);

    // Reset during OWN_2 drops everything regardless of requests.
    do_reset();
    req_2 = 1'b1;
    tick(); tick();
    rst = 1'b1; req_1 = 1'b1; req_2 = 1'b1; d2 = 8'hC3;
    tick();
    check("rst_mid_gnt_2", 32'(g2_a), 32'd0);
    check("rst_mid_bus", 32'(bus_a), 32'h00);
    check("rst_mid_valid", 32'(bv_a), 32'd0);
    rst = 1'b0;
    tick();
    check("rst_tie_gnt_1", 32'(g1_a), 32'd1);

    // MAX_HOLD = 1 with both requesting alternates every cycle.
    do_reset();
    req_1 = 1'b1; req_2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("alt_gnt_1", 32'(g1_b), 32'((i % 2) == 0));
      check("alt_gnt_2", 32'(g2_b), 32'((i % 2) == 1));
    end

    // A request pulse between edges is never seen.
    do_reset();
    req_1 = 1'b1;
    #3;
    req_1 = 1'b0;
    tick();
    check("glitch_gnt_1", 32'(g1_a), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 3) == 0) req_1 = ~req_1;
      if ($urandom_range(0, 3) == 0) req_2 = ~req_2;
      d1 = 8'($urandom);
      d2 = 8'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter N, default 8: width of the shared bus and of every data port.
REQ-002 Parameter MAX_HOLD, default 4: maximum number of consecutive cycles one device keeps the bus while the other is requesting; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_1, req_2  input  1 each  bus requests from device 1 and device 2, held high while the bus is wanted.
REQ-006 data_in_1, data_in_2  input  N each  data driven by device 1 and device 2.
REQ-007 gnt_1, gnt_2  output  1 each  registered grants, never both high.
REQ-008 bus  output  N  shared bus lines.
REQ-009 bus_valid  output  1  high when a grant is active (gnt_1 | gnt_2).
REQ-010 data_out_1, data_out_2  output  N each  bus readback to each device, always equal to bus.

Function
REQ-011 The FSM SHALL have states IDLE, OWN_1 and OWN_2; gnt_1 is high only in OWN_1, and gnt_2 is high only in OWN_2.
REQ-012 bus SHALL equal data_in_1 in OWN_1, data_in_2 in OWN_2, and all-zero in IDLE (combinational from state and data inputs; zero data latency).
REQ-013 From IDLE, a request seen at a clock edge SHALL produce the matching grant in the next cycle (one-cycle grant latency).
REQ-014 Tie in IDLE (both requests high): the grant goes to the device that was not the last owner (last_owner register; round robin).
REQ-015 In OWN_x, if req_x is low at an edge: go to OWN_y when req_y is high, else to IDLE; direct handover with no idle cycle.
REQ-016 hold_cnt SHALL load 1 on entry to any OWN state and increment each cycle the grant is kept, saturating at MAX_HOLD.
REQ-017 In OWN_x with req_x high, hold_cnt == MAX_HOLD and req_y high: the next state SHALL be OWN_y (forced preemption).
REQ-018 In OWN_x with req_x high and req_y low: the grant SHALL be kept indefinitely and hold_cnt SHALL stay saturated.
REQ-019 last_owner SHALL update to x on every entry to OWN_x.
REQ-020 When req_y rises while the counter is already saturated, preemption SHALL occur at the first edge at which req_y is seen high.
REQ-021 With MAX_HOLD = 1 and both requests held high, ownership SHALL alternate every cycle.
REQ-022 Input values are sampled only at clock edges; glitches between edges have no effect.

Reset
REQ-023 While rst is high at an edge: state = IDLE, gnt_1 = gnt_2 = 0, bus_valid = 0, bus = 0, hold_cnt = 0, and last_owner = 2 (so device 1 wins the first tie).
REQ-024 Reset asserted mid-grant SHALL drop the grant and zero bus in the cycle after the reset edge, regardless of the request inputs.
REQ-025 Reset SHALL take priority over every FSM transition.

Structure
REQ-026 A shared package bus_pkg SHALL hold the state enum (IDLE, OWN_1, OWN_2), the owner encoding and the MAX_HOLD default.
REQ-027 hold_cnt width SHALL be $clog2(MAX_HOLD+1).
REQ-028 One sub-module, bus_hold_timer, SHALL implement the load/increment/saturate counter and its "expired" flag.
REQ-029 The FSM and the bus multiplexing SHALL stay in bus_arbiter.

Verification
REQ-030 Reset, then req_1=1 and req_2=0 -> gnt_1=1 one cycle later; with data_in_1=8'hA5, bus = data_out_1 = data_out_2 = 8'hA5 and bus_valid=1.
REQ-031 From reset, both requests raised in the same cycle -> gnt_1 first; after release of req_1, gnt_2 in the next cycle with no IDLE gap.
REQ-032 MAX_HOLD=4, req_1 held, req_2 rises on cycle 2 of ownership -> device 1 keeps the bus for exactly 4 cycles, then gnt_2 follows.
REQ-033 req_2 alone held for 20 cycles -> gnt_2 stays high throughout, hold_cnt saturates at 4, and there are no spurious switches.
REQ-034 rst pulsed for one cycle during OWN_2 -> next cycle gnt_2=0, bus=8'h00, bus_valid=0; the next tie goes to device 1.
REQ-035 MAX_HOLD=1, both requests held high -> grants alternate 1,2,1,2, and a check fires if both grants are ever high together.
